// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the multimode VGA timing generator.
//   VGA_CW / VGA_DW   : timing-field and divider-field widths
//   VGA_DEF_*         : 640x480@60 reset-time configuration
//   vga_cfg_t         : packed timing configuration (shadow and active copies)
//   cfg_is_valid()    : true when a configuration can actually be scanned out
package vga_timing_pkg;

   localparam int unsigned VGA_CW = 12;
   localparam int unsigned VGA_DW = 8;

   localparam int unsigned VGA_DEF_H_ACT  = 640;
   localparam int unsigned VGA_DEF_H_FP   = 16;
   localparam int unsigned VGA_DEF_H_SYNC = 96;
   localparam int unsigned VGA_DEF_H_BP   = 48;
   localparam int unsigned VGA_DEF_V_ACT  = 480;
   localparam int unsigned VGA_DEF_V_FP   = 10;
   localparam int unsigned VGA_DEF_V_SYNC = 2;
   localparam int unsigned VGA_DEF_V_BP   = 33;
   localparam bit          VGA_DEF_H_POL  = 1'b0;
   localparam bit          VGA_DEF_V_POL  = 1'b0;
   localparam int unsigned VGA_DEF_DIV    = 1;

   typedef struct packed {
      logic [VGA_CW-1:0] h_act;
      logic [VGA_CW-1:0] h_fp;
      logic [VGA_CW-1:0] h_sync;
      logic [VGA_CW-1:0] h_bp;
      logic [VGA_CW-1:0] v_act;
      logic [VGA_CW-1:0] v_fp;
      logic [VGA_CW-1:0] v_sync;
      logic [VGA_CW-1:0] v_bp;
      logic              h_pol;
      logic              v_pol;
      logic [VGA_DW-1:0] div;
   } vga_cfg_t;

   // Porches may be zero; an empty active area, sync pulse or divider may not.
   function automatic logic cfg_is_valid(input vga_cfg_t c);
      return (c.h_act != '0) && (c.v_act != '0) && (c.h_sync != '0) &&
             (c.v_sync != '0) && (c.div != '0);
   endfunction

endpackage

// File: rtl/vga_timing_generator_multimode_if.sv
// Configuration channel of the multimode VGA timing generator.
//   cfg_valid / cfg_ready : handshake, transfer when both are high
//   cfg_h_* / cfg_v_*     : timing fields (pixel ticks / lines)
//   cfg_h_pol / cfg_v_pol : sync pulse level, 0 = active-low
//   cfg_div               : clk cycles per pixel tick
//   cfg_err               : one-clk pulse when an offered config was rejected
// master = config source, slave = timing generator.
interface vga_timing_generator_multimode_if
   import vga_timing_pkg::*;
#(
   parameter int unsigned CW = VGA_CW,
   parameter int unsigned DW = VGA_DW
);

   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_h_act;
   logic [CW-1:0] cfg_h_fp;
   logic [CW-1:0] cfg_h_sync;
   logic [CW-1:0] cfg_h_bp;
   logic [CW-1:0] cfg_v_act;
   logic [CW-1:0] cfg_v_fp;
   logic [CW-1:0] cfg_v_sync;
   logic [CW-1:0] cfg_v_bp;
   logic          cfg_h_pol;
   logic          cfg_v_pol;
   logic [DW-1:0] cfg_div;
   logic          cfg_err;

   modport master (
      output cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
             cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_pol, cfg_v_pol, cfg_div,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
             cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_pol, cfg_v_pol, cfg_div,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/vga_tick_divider.sv
// Pixel-tick divider: counts 0..div-1 and flags the last count.
//   clk, reset : clock, synchronous active-low reset
//   restart    : force the count back to 0 on the next clk
//   div        : clk cycles per tick (1 = tick every clk)
//   tick       : high while count == div-1
module vga_tick_divider #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          restart,
   input  logic [DW-1:0] div,
   output logic          tick
);

   logic [DW-1:0] count_q, count_d;

   assign tick = (count_q == (div - DW'(1)));

   always_comb begin
      count_d = count_q + DW'(1);
      if (restart || tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vga_timing_generator_multimode.sv
// Runtime-reconfigurable VGA timing generator.
//   clk, reset   : clock, synchronous active-low reset
//   cfg          : config channel (slave); accepted into a shadow, applied at frame end
//   pixel_tick   : one-clk pulse every div clks
//   h_sync/v_sync: sync outputs, level set by the active polarity
//   de           : inside the active area
//   h_pixel/v_pixel : shifted position while de, else 0
//   line_start/frame_start : one-clk strobes on the first clk of a new position 0
// All outputs except pixel_tick, cfg_ready and cfg_err are registered and lag the
// position counters by one clk. CW/DW must match the package field widths.
module vga_timing_generator_multimode
   import vga_timing_pkg::*;
#(
   parameter int unsigned CW         = VGA_CW,
   parameter int unsigned DW         = VGA_DW,
   parameter int unsigned H_SHIFT    = 0,
   parameter int unsigned V_SHIFT    = 0,
   parameter int unsigned DEF_H_ACT  = VGA_DEF_H_ACT,
   parameter int unsigned DEF_H_FP   = VGA_DEF_H_FP,
   parameter int unsigned DEF_H_SYNC = VGA_DEF_H_SYNC,
   parameter int unsigned DEF_H_BP   = VGA_DEF_H_BP,
   parameter int unsigned DEF_V_ACT  = VGA_DEF_V_ACT,
   parameter int unsigned DEF_V_FP   = VGA_DEF_V_FP,
   parameter int unsigned DEF_V_SYNC = VGA_DEF_V_SYNC,
   parameter int unsigned DEF_V_BP   = VGA_DEF_V_BP,
   parameter bit          DEF_H_POL  = VGA_DEF_H_POL,
   parameter bit          DEF_V_POL  = VGA_DEF_V_POL,
   parameter int unsigned DEF_DIV    = VGA_DEF_DIV
) (
   input  logic                   clk,
   input  logic                   reset,
   vga_timing_generator_multimode_if.slave cfg,
   output logic                   pixel_tick,
   output logic                   h_sync,
   output logic                   v_sync,
   output logic                   de,
   output logic [CW-H_SHIFT-1:0]  h_pixel,
   output logic [CW-V_SHIFT-1:0]  v_pixel,
   output logic                   line_start,
   output logic                   frame_start
);

   // Totals and sync edges are formed two bits wider so sums cannot wrap.
   localparam int unsigned TW = CW + 2;

   localparam vga_cfg_t DEF_CFG = '{
      h_act:  VGA_CW'(DEF_H_ACT),
      h_fp:   VGA_CW'(DEF_H_FP),
      h_sync: VGA_CW'(DEF_H_SYNC),
      h_bp:   VGA_CW'(DEF_H_BP),
      v_act:  VGA_CW'(DEF_V_ACT),
      v_fp:   VGA_CW'(DEF_V_FP),
      v_sync: VGA_CW'(DEF_V_SYNC),
      v_bp:   VGA_CW'(DEF_V_BP),
      h_pol:  DEF_H_POL,
      v_pol:  DEF_V_POL,
      div:    VGA_DW'(DEF_DIV)
   };

   vga_cfg_t      active_q, active_d, shadow_q, shadow_d, offer;
   logic          pending_q, pending_d, cfg_err_q;
   logic          xfer, apply;
   logic [CW-1:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
   logic          pos_new_q;
   logic [TW-1:0] h_pos_w, v_pos_w, h_total, v_total;
   logic [TW-1:0] hs_start, hs_end, vs_start, vs_end;
   logic          h_last, v_last;

   logic                  de_d, h_sync_d, v_sync_d, line_start_d, frame_start_d;
   logic                  de_q, h_sync_q, v_sync_q, line_start_q, frame_start_q;
   logic [CW-H_SHIFT-1:0] h_pixel_d, h_pixel_q;
   logic [CW-V_SHIFT-1:0] v_pixel_d, v_pixel_q;

   // ---------------------------------------------------------------- config handshake
   assign offer = '{
      h_act:  VGA_CW'(cfg.cfg_h_act),
      h_fp:   VGA_CW'(cfg.cfg_h_fp),
      h_sync: VGA_CW'(cfg.cfg_h_sync),
      h_bp:   VGA_CW'(cfg.cfg_h_bp),
      v_act:  VGA_CW'(cfg.cfg_v_act),
      v_fp:   VGA_CW'(cfg.cfg_v_fp),
      v_sync: VGA_CW'(cfg.cfg_v_sync),
      v_bp:   VGA_CW'(cfg.cfg_v_bp),
      h_pol:  cfg.cfg_h_pol,
      v_pol:  cfg.cfg_v_pol,
      div:    VGA_DW'(cfg.cfg_div)
   };

   assign cfg.cfg_ready = ~pending_q;
   assign cfg.cfg_err   = cfg_err_q;
   assign xfer          = cfg.cfg_valid && !pending_q;
   // Apply only needs pending, and transfers need !pending, so the two never collide.
   assign apply         = pixel_tick && h_last && v_last && pending_q;

   always_comb begin
      pending_d = pending_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      if (apply) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (xfer && cfg_is_valid(offer)) begin
         shadow_d  = offer;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         active_q  <= DEF_CFG;
         shadow_q  <= DEF_CFG;
         pending_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         cfg_err_q <= xfer && !cfg_is_valid(offer);
      end
   end

   // ---------------------------------------------------------------- pixel tick
   vga_tick_divider #(
      .DW (DW)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .restart (apply),
      .div     (DW'(active_q.div)),
      .tick    (pixel_tick)
   );

   // ---------------------------------------------------------------- position counters
   assign h_pos_w  = TW'(h_pos_q);
   assign v_pos_w  = TW'(v_pos_q);
   assign h_total  = TW'(active_q.h_act) + TW'(active_q.h_fp) + TW'(active_q.h_sync) +
                     TW'(active_q.h_bp);
   assign v_total  = TW'(active_q.v_act) + TW'(active_q.v_fp) + TW'(active_q.v_sync) +
                     TW'(active_q.v_bp);
   assign h_last   = (h_pos_w == (h_total - TW'(1)));
   assign v_last   = (v_pos_w == (v_total - TW'(1)));
   assign hs_start = TW'(active_q.h_act) + TW'(active_q.h_fp);
   assign hs_end   = hs_start + TW'(active_q.h_sync);
   assign vs_start = TW'(active_q.v_act) + TW'(active_q.v_fp);
   assign vs_end   = vs_start + TW'(active_q.v_sync);

   always_comb begin
      h_pos_d = h_pos_q;
      v_pos_d = v_pos_q;
      if (pixel_tick) begin
         if (h_last) begin
            h_pos_d = '0;
            v_pos_d = v_last ? '0 : v_pos_q + CW'(1);
         end else begin
            h_pos_d = h_pos_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         h_pos_q   <= '0;
         v_pos_q   <= '0;
         pos_new_q <= 1'b1;   // position 0 after reset counts as freshly produced
      end else begin
         h_pos_q   <= h_pos_d;
         v_pos_q   <= v_pos_d;
         pos_new_q <= pixel_tick;
      end
   end

   // ---------------------------------------------------------------- output decode
   always_comb begin
      de_d          = (h_pos_w < TW'(active_q.h_act)) && (v_pos_w < TW'(active_q.v_act));
      h_sync_d      = ((h_pos_w >= hs_start) && (h_pos_w < hs_end)) ?
                      active_q.h_pol : ~active_q.h_pol;
      v_sync_d      = ((v_pos_w >= vs_start) && (v_pos_w < vs_end)) ?
                      active_q.v_pol : ~active_q.v_pol;
      h_pixel_d     = de_d ? (CW-H_SHIFT)'(h_pos_q >> H_SHIFT) : '0;
      v_pixel_d     = de_d ? (CW-V_SHIFT)'(v_pos_q >> V_SHIFT) : '0;
      // Strobe only on the clk after the tick that produced 0, not while it is held.
      line_start_d  = pos_new_q && (h_pos_q == '0);
      frame_start_d = line_start_d && (v_pos_q == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         de_q          <= 1'b0;
         h_sync_q      <= ~DEF_H_POL;
         v_sync_q      <= ~DEF_V_POL;
         h_pixel_q     <= '0;
         v_pixel_q     <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         de_q          <= de_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         h_pixel_q     <= h_pixel_d;
         v_pixel_q     <= v_pixel_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign de          = de_q;
   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign h_pixel     = h_pixel_q;
   assign v_pixel     = v_pixel_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator_multimode.sv
// Directed bench for vga_timing_generator_multimode. Horizontal defaults are the
// 640x480 values; the vertical defaults are shortened to 4/1/2/1 lines so a full
// default frame is 6400 clks. H_SHIFT = V_SHIFT = 1.
// Edge n counts rising edges since reset release; outputs sampled 1 ns after it.
module tb_vga_timing_generator_multimode;
   import vga_timing_pkg::*;

   localparam int unsigned CW = 12;
   localparam int unsigned DW = 8;
   // Small-mode frame start (first decode after the apply edge 12800) and C2 start.
   localparam int unsigned B1 = 12801;
   localparam int unsigned B2 = B1 + 192;

   logic          clk = 1'b0;
   logic          reset;
   logic          pixel_tick, h_sync, v_sync, de, line_start, frame_start;
   logic [CW-2:0] h_pixel, v_pixel;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned ecnt     = 0;

   always #5 clk = ~clk;

   vga_timing_generator_multimode_if #(.CW(CW), .DW(DW)) cfg_bus ();

   vga_timing_generator_multimode #(
      .CW         (CW),
      .DW         (DW),
      .H_SHIFT    (1),
      .V_SHIFT    (1),
      .DEF_V_ACT  (4),
      .DEF_V_FP   (1),
      .DEF_V_SYNC (2),
      .DEF_V_BP   (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg         (cfg_bus.slave),
      .pixel_tick  (pixel_tick),
      .h_sync      (h_sync),
      .v_sync      (v_sync),
      .de          (de),
      .h_pixel     (h_pixel),
      .v_pixel     (v_pixel),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   task automatic run_to(input int unsigned n);
      if (ecnt < n) begin
         while (ecnt < n) begin
            @(posedge clk);
            ecnt++;
         end
         #1;
      end
   endtask

   task automatic drive_cfg(input int unsigned ha, hf, hs, hb, va, vf, vs, vb,
                            input bit hp, vp, input int unsigned dv);
      cfg_bus.cfg_h_act  = CW'(ha);
      cfg_bus.cfg_h_fp   = CW'(hf);
      cfg_bus.cfg_h_sync = CW'(hs);
      cfg_bus.cfg_h_bp   = CW'(hb);
      cfg_bus.cfg_v_act  = CW'(va);
      cfg_bus.cfg_v_fp   = CW'(vf);
      cfg_bus.cfg_v_sync = CW'(vs);
      cfg_bus.cfg_v_bp   = CW'(vb);
      cfg_bus.cfg_h_pol  = hp;
      cfg_bus.cfg_v_pol  = vp;
      cfg_bus.cfg_div    = DW'(dv);
   endtask

   task automatic check_in_reset(input string pfx);
      check_val({pfx, "_hsync"}, 32'(h_sync), 1);
      check_val({pfx, "_vsync"}, 32'(v_sync), 1);
      check_val({pfx, "_de"}, 32'(de), 0);
      check_val({pfx, "_hpix"}, 32'(h_pixel), 0);
      check_val({pfx, "_ls"}, 32'(line_start), 0);
      check_val({pfx, "_fs"}, 32'(frame_start), 0);
      check_val({pfx, "_ready"}, 32'(cfg_bus.cfg_ready), 1);
      check_val({pfx, "_err"}, 32'(cfg_bus.cfg_err), 0);
   endtask

   initial begin
      reset = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      drive_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2);
      repeat (3) @(posedge clk);
      #1;
      check_in_reset("rst0");

      // ---------------- default timing, div 1
      reset = 1'b1;
      ecnt  = 0;
      run_to(1);
      check_val("def_fs0", 32'(frame_start), 1);
      check_val("def_ls0", 32'(line_start), 1);
      check_val("def_de0", 32'(de), 1);
      check_val("def_hs0", 32'(h_sync), 1);
      run_to(2);
      check_val("def_fs1", 32'(frame_start), 0);
      check_val("def_tick", 32'(pixel_tick), 1);
      run_to(3);
      check_val("def_hpix2", 32'(h_pixel), 1);
      run_to(640);
      check_val("def_de639", 32'(de), 1);
      check_val("def_hpix639", 32'(h_pixel), 319);
      run_to(641);
      check_val("def_de640", 32'(de), 0);
      check_val("def_hpix640", 32'(h_pixel), 0);
      run_to(656);
      check_val("def_hs655", 32'(h_sync), 1);
      run_to(657);
      check_val("def_hs656", 32'(h_sync), 0);
      run_to(752);
      check_val("def_hs751", 32'(h_sync), 0);
      run_to(753);
      check_val("def_hs752", 32'(h_sync), 1);
      run_to(801);
      check_val("def_ls_l1", 32'(line_start), 1);
      check_val("def_fs_l1", 32'(frame_start), 0);
      check_val("def_vpix_l1", 32'(v_pixel), 0);
      run_to(2401);
      check_val("def_de_l3", 32'(de), 1);
      check_val("def_vpix_l3", 32'(v_pixel), 1);
      run_to(3201);
      check_val("def_de_l4", 32'(de), 0);
      check_val("def_vs_l4", 32'(v_sync), 1);
      run_to(4001);
      check_val("def_vs_l5", 32'(v_sync), 0);
      run_to(4801);
      check_val("def_vs_l6", 32'(v_sync), 0);
      run_to(5601);
      check_val("def_vs_l7", 32'(v_sync), 1);
      run_to(6400);
      check_val("def_fs_end", 32'(frame_start), 0);
      run_to(6401);
      check_val("def_fs_f1", 32'(frame_start), 1);

      // ---------------- small config offered mid-frame, applied at frame end
      run_to(7000);
      cfg_bus.cfg_valid = 1'b1;
      run_to(7001);
      check_val("sm_ready_pend", 32'(cfg_bus.cfg_ready), 0);
      check_val("sm_err", 32'(cfg_bus.cfg_err), 0);
      cfg_bus.cfg_valid = 1'b0;
      run_to(12799);
      check_val("sm_ready_late", 32'(cfg_bus.cfg_ready), 0);
      run_to(12800);
      check_val("sm_ready_apply", 32'(cfg_bus.cfg_ready), 1);
      check_val("sm_old_de", 32'(de), 0);
      check_val("sm_old_hs", 32'(h_sync), 1);
      check_val("sm_old_vs", 32'(v_sync), 1);
      run_to(B1);
      check_val("sm_fs0", 32'(frame_start), 1);
      check_val("sm_de0", 32'(de), 1);
      check_val("sm_hs0", 32'(h_sync), 0);
      check_val("sm_vs0", 32'(v_sync), 0);
      check_val("sm_tick0", 32'(pixel_tick), 1);
      run_to(B1 + 1);
      check_val("sm_fs_hold", 32'(frame_start), 0);
      check_val("sm_de1", 32'(de), 1);
      check_val("sm_tick1", 32'(pixel_tick), 0);
      run_to(B1 + 7);
      check_val("sm_hpix3", 32'(h_pixel), 1);
      run_to(B1 + 8);
      check_val("sm_de_h4", 32'(de), 0);
      run_to(B1 + 9);
      check_val("sm_hs_c9", 32'(h_sync), 0);
      run_to(B1 + 10);
      check_val("sm_hs_c10", 32'(h_sync), 1);
      run_to(B1 + 13);
      check_val("sm_hs_c13", 32'(h_sync), 1);
      run_to(B1 + 14);
      check_val("sm_hs_c14", 32'(h_sync), 0);
      run_to(B1 + 16);
      check_val("sm_ls_l1", 32'(line_start), 1);
      check_val("sm_vpix_l1", 32'(v_pixel), 0);
      run_to(B1 + 17);
      check_val("sm_ls_hold", 32'(line_start), 0);
      run_to(B1 + 32);
      check_val("sm_de_l2", 32'(de), 1);
      check_val("sm_vpix_l2", 32'(v_pixel), 1);
      run_to(B1 + 48);
      check_val("sm_de_l3", 32'(de), 0);

      // ---------------- rejected configs: div 0, then h_act 0
      run_to(B1 + 50);
      drive_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0);
      cfg_bus.cfg_valid = 1'b1;
      run_to(B1 + 51);
      check_val("bad_div_err", 32'(cfg_bus.cfg_err), 1);
      check_val("bad_div_ready", 32'(cfg_bus.cfg_ready), 1);
      cfg_bus.cfg_valid = 1'b0;
      run_to(B1 + 52);
      check_val("bad_div_err_off", 32'(cfg_bus.cfg_err), 0);
      run_to(B1 + 60);
      drive_cfg(0, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2);
      cfg_bus.cfg_valid = 1'b1;
      run_to(B1 + 61);
      check_val("bad_hact_err", 32'(cfg_bus.cfg_err), 1);
      check_val("bad_hact_ready", 32'(cfg_bus.cfg_ready), 1);
      cfg_bus.cfg_valid = 1'b0;
      run_to(B1 + 62);
      check_val("bad_hact_err_off", 32'(cfg_bus.cfg_err), 0);
      run_to(B1 + 64);
      check_val("sm_vs_l4", 32'(v_sync), 1);
      run_to(B1 + 80);
      check_val("sm_vs_l5", 32'(v_sync), 0);
      run_to(B1 + 95);
      check_val("sm_fs_c95", 32'(frame_start), 0);
      run_to(B1 + 96);
      check_val("sm_fs_96", 32'(frame_start), 1);
      run_to(B1 + 98);
      check_val("sm_de_f2", 32'(de), 1);

      // ---------------- C2 accepted, C3 held on valid while C2 pending
      run_to(B1 + 100);
      drive_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 1);
      cfg_bus.cfg_valid = 1'b1;
      run_to(B1 + 101);
      check_val("c2_ready_pend", 32'(cfg_bus.cfg_ready), 0);
      run_to(B1 + 106);
      check_val("sm_hs_f2", 32'(h_sync), 1);
      run_to(B1 + 190);
      check_val("c3_ready_wait", 32'(cfg_bus.cfg_ready), 0);
      run_to(B1 + 191);
      check_val("c3_ready_apply", 32'(cfg_bus.cfg_ready), 1);
      run_to(B2);
      check_val("c3_accepted", 32'(cfg_bus.cfg_ready), 0);
      cfg_bus.cfg_valid = 1'b0;
      check_val("c2_fs0", 32'(frame_start), 1);
      check_val("c2_hs0", 32'(h_sync), 1);
      check_val("c2_de0", 32'(de), 1);
      check_val("c2_hpix0", 32'(h_pixel), 0);
      run_to(B2 + 1);
      check_val("c2_hpix1", 32'(h_pixel), 0);
      check_val("c2_fs1", 32'(frame_start), 0);
      run_to(B2 + 2);
      check_val("c2_hpix2", 32'(h_pixel), 1);
      run_to(B2 + 3);
      check_val("c2_hpix3", 32'(h_pixel), 1);
      run_to(B2 + 4);
      check_val("c2_hpix4", 32'(h_pixel), 0);
      check_val("c2_de4", 32'(de), 0);
      run_to(B2 + 5);
      check_val("c2_hs5", 32'(h_sync), 0);
      run_to(B2 + 7);
      check_val("c2_hs7", 32'(h_sync), 1);
      run_to(B2 + 8);
      check_val("c2_ls8", 32'(line_start), 1);

      // ---------------- reset mid-frame with C3 pending
      run_to(B2 + 20);
      reset = 1'b0;
      run_to(B2 + 22);
      check_in_reset("rst1");
      reset = 1'b1;
      ecnt  = 0;
      run_to(1);
      check_val("rst1_fs", 32'(frame_start), 1);
      check_val("rst1_ready", 32'(cfg_bus.cfg_ready), 1);
      run_to(641);
      check_val("rst1_de640", 32'(de), 0);
      run_to(657);
      check_val("rst1_hs656", 32'(h_sync), 0);
      run_to(6401);
      check_val("rst1_fs_f1", 32'(frame_start), 1);
      run_to(6406);
      check_val("rst1_de_h4", 32'(de), 1);
      run_to(6401 + 656);
      check_val("rst1_hs_f1", 32'(h_sync), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
